// File: rtl/bit_vector_sum_acc.sv
// Frame accumulator behind the popcount stage. It totals per-word counts and beats per frame
// with saturation, then holds the result on a valid/ready port until the consumer takes it.
module bit_vector_sum_acc #(
  parameter int DATA_W = 8,
  parameter int POS_W  = $clog2(DATA_W),
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W:0]   in_sum,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [CNT_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_len,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready
);

  // state | meaning
  // IDLE  | reset state, leaves on the first clock after reset release
  // ACC   | accepting beats (in_ready rises one cycle after entry from DONE)
  // DONE  | frame result pending on the output port
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] acc_sum;
  logic [CNT_W-1:0] acc_len;
  logic             acc_sat;

  logic [CNT_W:0]   sum_ext;
  logic [CNT_W:0]   len_ext;
  logic [CNT_W-1:0] sum_nxt;
  logic [CNT_W-1:0] len_nxt;
  logic             sat_nxt;
  logic             beat_acc;

  assign beat_acc = in_valid && in_ready;

  // One extra bit of headroom exposes the carry; a carry clamps to all-ones.
  always_comb begin
    sum_ext = {1'b0, acc_sum} + {{(CNT_W - POS_W){1'b0}}, in_sum};
    len_ext = {1'b0, acc_len} + {{CNT_W{1'b0}}, 1'b1};
    sum_nxt = sum_ext[CNT_W] ? {CNT_W{1'b1}} : sum_ext[CNT_W-1:0];
    len_nxt = len_ext[CNT_W] ? {CNT_W{1'b1}} : len_ext[CNT_W-1:0];
    sat_nxt = acc_sat | sum_ext[CNT_W] | len_ext[CNT_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      acc_sum   <= '0;
      acc_len   <= '0;
      acc_sat   <= 1'b0;
      out_sum   <= '0;
      out_len   <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= ACC;
          in_ready <= 1'b1;
        end
        ACC: begin
          in_ready <= 1'b1;
          if (beat_acc) begin
            if (in_last) begin
              out_sum   <= sum_nxt;
              out_len   <= len_nxt;
              out_sat   <= sat_nxt;
              out_valid <= 1'b1;
              acc_sum   <= '0;
              acc_len   <= '0;
              acc_sat   <= 1'b0;
              in_ready  <= 1'b0;
              state     <= DONE;
            end else begin
              acc_sum <= sum_nxt;
              acc_len <= len_nxt;
              acc_sat <= sat_nxt;
            end
          end
        end
        DONE: begin
          in_ready <= 1'b0;
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= ACC;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bit_vector_sum_acc.md
# bit_vector_sum_acc

Frame-level accumulator placed directly downstream of the `bit_vector_sum` popcount stage. Each beat delivers a per-word set-bit count, the matching valid strobe and a last-of-frame marker. The block totals those counts over a frame and counts the frame's beats. It then presents the frame total, the beat count and a saturation flag on a valid/ready output port, holding them until the consumer takes them.

## Interface
- `DATA_W`, 8: width of the word counted by the upstream popcount stage.
- `POS_W`, `$clog2(DATA_W)`: the per-word count is `POS_W+1` bits wide.
- `CNT_W`, 16: width of the frame total and beat counters; must be ≥ `POS_W+1`.

- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_sum` input `POS_W+1`: per-word set-bit count from the popcount stage.
- `in_valid` input 1: `in_sum` and `in_last` are valid this cycle.
- `in_last` input 1: this beat is the final beat of the frame.
- `in_ready` output 1: block accepts a beat this cycle.
- `out_sum` output `CNT_W`: frame total of `in_sum`, saturating.
- `out_len` output `CNT_W`: number of beats in the frame, saturating.
- `out_sat` output 1: `out_sum` or `out_len` saturated during the frame.
- `out_valid` output 1: output fields are valid.
- `out_ready` input 1: consumer takes the result this cycle.

## Operation
- **States:**
  - `IDLE`: reset state.
  - `ACC`: accepting beats.
  - `DONE`: result pending on the output port.
- **Transitions:**
  - `IDLE` → `ACC` on the first clock after reset release, unconditionally.
  - `ACC` → `DONE` on an accepted beat with `in_last` = 1.
  - `DONE` → `ACC` on the output handshake.
- **`in_ready`** is a register. It is 1 only in `ACC` and 0 in `IDLE` and `DONE`. It never depends combinationally on `out_ready`.
- **Beat accept** is `in_valid && in_ready`.
- **On an accepted beat:**
  - `acc_sum <= sat(acc_sum + in_sum)`.
  - `acc_len <= sat(acc_len + 1)`.
  - The sticky `acc_sat` is set if either addition would exceed `2^CNT_W - 1`.
- **Saturation arithmetic:** additions are computed at `CNT_W+1` bits. The result clamps to `2^CNT_W - 1`, never wraps, and stays clamped for the rest of the frame.
- **On an accepted last beat:**
  - `out_sum`, `out_len` and `out_sat` load the post-update values, including the current beat.
  - `out_valid <= 1`.
  - The accumulators clear to 0.
- **`in_sum` is used as-is.** Values above `DATA_W` are not checked.
- **`in_valid` = 0** leaves all state unchanged. Gaps inside a frame are allowed.
- **Output handshake** is `out_valid && out_ready`. It clears `out_valid`, returns the FSM to `ACC` and sets `in_ready` for the next cycle.
- **Output stability:** while `out_valid` = 1 and `out_ready` = 0, `out_sum`, `out_len` and `out_sat` stay stable.
- **Single-beat frame** (`in_last` on the first beat) gives `out_len` = 1 and `out_sum` = `in_sum`.
- **Reset mid-frame or mid-handshake:** the partial frame and any pending result are discarded, with no output.

## Timing
- **Reset values:**
  - `in_ready` = 0, `out_valid` = 0, `out_sat` = 0.
  - `out_sum` = 0, `out_len` = 0.
  - Internal accumulators = 0; state = `IDLE`.
- **First accept:** `in_ready` rises on the first rising edge after `rst` deasserts. The first beat can be accepted on the second edge.
- **Latency:** `out_valid` asserts one cycle after the edge that accepts the last beat.
- **Throughput:** a frame of N beats with `out_ready` held high occupies N + 2 cycles:
  - N accept cycles;
  - 1 cycle in `DONE`, during which the handshake occurs;
  - 1 cycle for `in_ready` to re-rise.
- **Earliest next accept:** the first beat of the next frame is accepted at the earliest 2 cycles after the output handshake edge.
- **Reset** is asynchronous on assertion. Outputs take their reset values immediately, without waiting for a clock edge.

## Test plan
Bench settings: `DATA_W` = 8, `CNT_W` = 4 (maximum value 15).
- **Basic frame:** beats `in_sum` = 3, 5, 2 with `in_last` on the third; `out_ready` = 1 → one cycle later `out_valid` = 1, `out_sum` = 10, `out_len` = 3, `out_sat` = 0.
- **Backpressure:** complete a frame with `out_ready` = 0 for 5 cycles, driving `in_valid` = 1 throughout → `in_ready` stays 0, outputs hold stable, no beat is absorbed. Raise `out_ready` → handshake, then `in_ready` = 1 on the next cycle.
- **Sum saturation:** beats 8, 8, 8 with last → `out_sum` = 15, `out_sat` = 1, `out_len` = 3. The next frame with a single beat of 1 → `out_sum` = 1, `out_sat` = 0.
- **Length saturation and gaps:** 20 beats of `in_sum` = 0 with random `in_valid` gaps, last on the 20th → `out_len` = 15, `out_sum` = 0, `out_sat` = 1.
- **Single-beat frame:** `in_sum` = 8 with `in_last` = 1 → `out_sum` = 8, `out_len` = 1.
- **Async reset mid-frame:** accept 2 beats, pulse `rst` between clock edges → outputs are 0 immediately. A following frame of one beat (`in_sum` = 4) gives `out_sum` = 4, `out_len` = 1.
